// File: rtl/dino_jump_collision_ctrl_if.sv
// Signal bundle between the game/obstacle side and the dino jump/collision controller.
// The master drives tick, button and obstacle line; the slave returns dino state and score.
interface dino_jump_collision_ctrl_if #(
    parameter int unsigned SCORE_W = 8
) ();
    logic               tick;
    logic               jump_btn;
    logic [7:0]         ledLine;
    logic               dino_up;
    logic               game_over;
    logic [SCORE_W-1:0] score;

    modport master (
        output tick, jump_btn, ledLine,
        input  dino_up, game_over, score
    );

    modport slave (
        input  tick, jump_btn, ledLine,
        output dino_up, game_over, score
    );
endinterface

// File: rtl/dino_jump_collision_ctrl.sv
// Dino jump state machine: button sync/edge detect, tick-stepped jump timing,
// collision at the dino column and saturating cleared-obstacle score.
module dino_jump_collision_ctrl #(
    parameter int unsigned DINO_COL   = 7,
    parameter int unsigned JUMP_TICKS = 3,
    parameter int unsigned SCORE_W    = 8
) (
    input logic                      clk,
    input logic                      reset,
    dino_jump_collision_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StRun, StAir, StOver} state_e;

    localparam logic [2:0]         ColIdx   = 3'(DINO_COL);
    localparam logic [3:0]         AirInit  = 4'(JUMP_TICKS - 1);
    localparam logic [SCORE_W-1:0] ScoreMax = '1;

    state_e             state_q, state_d;
    logic [3:0]         air_cnt_q, air_cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               prev_col_q, prev_col_d;
    logic               jump_pend_q, jump_pend_d;
    logic               sync1_q, sync2_q, btn_prev_q;
    logic               btn_rise;
    logic               pend_clr;
    logic               col;

    assign col      = bus.ledLine[ColIdx];
    assign btn_rise = sync2_q & ~btn_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            btn_prev_q  <= 1'b0;
            state_q     <= StRun;
            air_cnt_q   <= '0;
            score_q     <= '0;
            prev_col_q  <= 1'b0;
            jump_pend_q <= 1'b0;
        end else begin
            sync1_q     <= bus.jump_btn;
            sync2_q     <= sync1_q;
            btn_prev_q  <= sync2_q;
            state_q     <= state_d;
            air_cnt_q   <= air_cnt_d;
            score_q     <= score_d;
            prev_col_q  <= prev_col_d;
            jump_pend_q <= jump_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        air_cnt_d  = air_cnt_q;
        score_d    = score_q;
        prev_col_d = prev_col_q;
        pend_clr   = 1'b0;
        if (bus.tick) begin
            unique case (state_q)
                StRun: begin
                    prev_col_d = col;
                    // Collision wins over a same-tick jump; the request is dropped.
                    if (col) begin
                        state_d  = StOver;
                        pend_clr = 1'b1;
                    end else begin
                        if (prev_col_q && (score_q != ScoreMax)) begin
                            score_d = score_q + 1'b1;
                        end
                        if (jump_pend_q) begin
                            state_d   = StAir;
                            air_cnt_d = AirInit;
                            pend_clr  = 1'b1;
                        end
                    end
                end
                StAir: begin
                    prev_col_d = col;
                    if (prev_col_q && !col && (score_q != ScoreMax)) begin
                        score_d = score_q + 1'b1;
                    end
                    // Landing discards any press made while airborne.
                    if (air_cnt_q == 4'd0) begin
                        state_d  = StRun;
                        pend_clr = 1'b1;
                    end else begin
                        air_cnt_d = air_cnt_q - 4'd1;
                    end
                end
                StOver: begin
                    if (jump_pend_q) begin
                        state_d    = StRun;
                        score_d    = '0;
                        prev_col_d = col;
                        pend_clr   = 1'b1;
                    end
                end
                default: state_d = StRun;
            endcase
        end
        // A fresh edge in the consuming cycle starts a new request.
        if (btn_rise) begin
            jump_pend_d = 1'b1;
        end else if (pend_clr) begin
            jump_pend_d = 1'b0;
        end else begin
            jump_pend_d = jump_pend_q;
        end
    end

    assign bus.dino_up   = (state_q == StAir);
    assign bus.game_over = (state_q == StOver);
    assign bus.score     = score_q;
endmodule

// File: tb/tb_dino_jump_collision_ctrl.sv
// Directed bench for dino_jump_collision_ctrl: an 8-bit and a 2-bit score instance
// share the same stimulus so saturation is visible alongside normal play.
module tb_dino_jump_collision_ctrl;
    logic       clk;
    logic       reset;
    logic       tick;
    logic       jump_btn;
    logic [7:0] ledLine;

    int n_cmp;
    int n_bad;

    dino_jump_collision_ctrl_if #(.SCORE_W(8)) bus8 ();
    dino_jump_collision_ctrl_if #(.SCORE_W(2)) bus2 ();

    assign bus8.tick     = tick;
    assign bus8.jump_btn = jump_btn;
    assign bus8.ledLine  = ledLine;
    assign bus2.tick     = tick;
    assign bus2.jump_btn = jump_btn;
    assign bus2.ledLine  = ledLine;

    dino_jump_collision_ctrl #(.DINO_COL(7), .JUMP_TICKS(3), .SCORE_W(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    dino_jump_collision_ctrl #(.DINO_COL(7), .JUMP_TICKS(3), .SCORE_W(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One game step; outputs are then sampled 1 time unit after the tick edge.
    task automatic do_tick(input logic [7:0] line);
        @(negedge clk);
        ledLine = line;
        tick    = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic press();
        @(negedge clk);
        jump_btn = 1'b1;
        idle(4);
        jump_btn = 1'b0;
        idle(3);
    endtask

    // Several rising edges before any tick: must collapse into one request.
    task automatic press_glitchy();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            jump_btn = 1'b1;
            idle(3);
            jump_btn = 1'b0;
            idle(3);
        end
    endtask

    task automatic check_state(input string tag, input logic up, input logic over,
                               input int sc8);
        check({tag, ".up"}, 32'(bus8.dino_up), 32'(up));
        check({tag, ".over"}, 32'(bus8.game_over), 32'(over));
        check({tag, ".score"}, 32'(bus8.score), 32'(sc8));
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        tick     = 1'b0;
        jump_btn = 1'b0;
        ledLine  = 8'h00;
        idle(2);
        check_state("rst", 1'b0, 1'b0, 0);
        check("rst.score2", 32'(bus2.score), 32'd0);
        reset = 1'b1;
        idle(2);

        // Asynchronous reset while airborne.
        press();
        do_tick(8'h00);
        check("air.up", 32'(bus8.dino_up), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_state("midair_rst", 1'b0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) do_tick(8'h00);
        check_state("idle10", 1'b0, 1'b0, 0);

        // Five clean jumps over a two-wide obstacle; the third press is glitchy.
        for (int j = 0; j < 5; j++) begin
            if (j == 2) press_glitchy();
            else press();
            do_tick(8'h00);
            check_state($sformatf("j%0d.t0", j), 1'b1, 1'b0, j);
            do_tick(8'h80);
            check_state($sformatf("j%0d.t1", j), 1'b1, 1'b0, j);
            do_tick(8'h80);
            check_state($sformatf("j%0d.t2", j), 1'b1, 1'b0, j);
            do_tick(8'h00);
            check_state($sformatf("j%0d.land", j), 1'b0, 1'b0, j + 1);
            do_tick(8'h00);
            check_state($sformatf("j%0d.after", j), 1'b0, 1'b0, j + 1);
            if (j == 3) check("sat.score2", 32'(bus2.score), 32'd3);
        end
        check("sat5.score2", 32'(bus2.score), 32'd3);

        // Collision without a press, then frozen score.
        do_tick(8'h80);
        check_state("hit", 1'b0, 1'b1, 5);
        do_tick(8'h00);
        do_tick(8'h80);
        do_tick(8'h00);
        check_state("frozen", 1'b0, 1'b1, 5);

        // Restart from OVER, then a second press during AIR is not buffered.
        press();
        do_tick(8'h00);
        check_state("restart", 1'b0, 1'b0, 0);
        check("restart.score2", 32'(bus2.score), 32'd0);
        press();
        do_tick(8'h00);
        check_state("rj.t0", 1'b1, 1'b0, 0);
        press();
        do_tick(8'h00);
        check_state("rj.t1", 1'b1, 1'b0, 0);
        do_tick(8'h00);
        check_state("rj.t2", 1'b1, 1'b0, 0);
        do_tick(8'h00);
        check_state("rj.land", 1'b0, 1'b0, 0);
        do_tick(8'h00);
        check_state("rj.nobuf", 1'b0, 1'b0, 0);

        // Jump request and obstacle on the same tick: collision wins.
        press();
        do_tick(8'h80);
        check_state("same_tick", 1'b0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
